dp_operand_feeder: RTL

- Transmit side of the dot-product operand interface.
- Buffers one PIXEL_N-element pixel/weight vector loaded over a simple write port.
- On start, pulses the engine reset, then streams the vector as PARALLEL-lane beats, one beat per cycle.
- Waits a fixed drain time, samples the engine's value output, and presents it with a valid/ready handshake.

---
 rtl/dp_operand_feeder.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dp_operand_feeder.sv
// -----------------------------------------------------------------------------
// dp_operand_feeder
//
// Transmit side of the dot-product operand interface. Holds one PIXEL_N-element
// pixel/weight vector written through a simple load port. A start request
// pulses the engine reset for one cycle, streams the vector as PARALLEL-lane
// beats (one beat per cycle, zero-padded past PIXEL_N), waits DRAIN cycles for
// the engine to settle, captures dp_value and offers it on a valid/ready port.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   GlobalReset_n  asynchronous active-low reset
//   ld_valid       write strobe for the operand buffer (honoured only in IDLE)
//   ld_index       element index; values >= PIXEL_N are dropped
//   ld_pixel       pixel to store
//   ld_weight      weight to store
//   start          begin one dot-product run (honoured only in IDLE)
//   busy           high whenever the feeder is not idle
//   dp_reset       one-cycle active-high reset pulse to the engine
//   Pixels         lane j at [j*PIXEL_SIZE +: PIXEL_SIZE]
//   Weights        lane j at [j*WEIGHT_SIZE +: WEIGHT_SIZE]
//   dp_value       engine result
//   res_valid      captured result available
//   res_value      captured result (keeps its value after the handshake)
//   res_ready      consumer accepts the result
//
// Every output is a flop: next-cycle values are computed from the next state
// and loaded on the same edge as the state register.
// -----------------------------------------------------------------------------
module dp_operand_feeder #(
  parameter int PIXEL_N     = 10,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int PARALLEL    = 2,
  parameter int VAL_SIZE    = 26,
  parameter int DRAIN       = 12,
  localparam int IDX_W      = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1
) (
  input  logic                              clk,
  input  logic                              GlobalReset_n,
  input  logic                              ld_valid,
  input  logic [IDX_W-1:0]                  ld_index,
  input  logic [PIXEL_SIZE-1:0]             ld_pixel,
  input  logic [WEIGHT_SIZE-1:0]            ld_weight,
  input  logic                              start,
  output logic                              busy,
  output logic                              dp_reset,
  output logic [PARALLEL*PIXEL_SIZE-1:0]    Pixels,
  output logic [PARALLEL*WEIGHT_SIZE-1:0]   Weights,
  input  logic [VAL_SIZE-1:0]               dp_value,
  output logic                              res_valid,
  output logic [VAL_SIZE-1:0]               res_value,
  input  logic                              res_ready
);

  localparam int BEATS     = (PIXEL_N + PARALLEL - 1) / PARALLEL;
  localparam int SLOTS     = BEATS * PARALLEL;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DRAIN_W   = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam int PIX_BUS_W = PARALLEL * PIXEL_SIZE;
  localparam int WGT_BUS_W = PARALLEL * WEIGHT_SIZE;

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0]  BEAT_ONE   = BEAT_W'(1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [BEAT_W-1:0]      beat_r;
  logic [BEAT_W-1:0]      beat_nxt_s;
  logic [BEAT_W-1:0]      beat_sel_s;
  logic [DRAIN_W-1:0]     drain_r;
  logic [DRAIN_W-1:0]     drain_nxt_s;
  logic                   bus_en_s;
  logic                   dp_reset_nxt_s;
  logic                   res_valid_nxt_s;
  logic [VAL_SIZE-1:0]    res_value_nxt_s;
  logic                   load_en_s;

  logic                   busy_r;
  logic                   dp_reset_r;
  logic [PIX_BUS_W-1:0]   pixels_r;
  logic [WGT_BUS_W-1:0]   weights_r;
  logic                   res_valid_r;
  logic [VAL_SIZE-1:0]    res_value_r;

  // Buffer flattened to a whole number of beats; slots past PIXEL_N read as 0
  // so the last beat is padded without any per-lane range check.
  logic [SLOTS*PIXEL_SIZE-1:0]  pix_pad_s;
  logic [SLOTS*WEIGHT_SIZE-1:0] wgt_pad_s;
  logic [PIX_BUS_W-1:0]         beat_pix_s;
  logic [WGT_BUS_W-1:0]         beat_wgt_s;

  assign load_en_s = ld_valid && (state_r == ST_IDLE);

  for (genvar e = 0; e < SLOTS; e++) begin : g_slot
    if (e < PIXEL_N) begin : g_live
      logic [PIXEL_SIZE-1:0]  pix_r;
      logic [WEIGHT_SIZE-1:0] wgt_r;

      // One buffer entry: written by a matching load while idle
      always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
          pix_r <= {PIXEL_SIZE{1'b0}};
          wgt_r <= {WEIGHT_SIZE{1'b0}};
        end else if (load_en_s && (ld_index == IDX_W'(e))) begin
          pix_r <= ld_pixel;
          wgt_r <= ld_weight;
        end else begin
          pix_r <= pix_r;
          wgt_r <= wgt_r;
        end
      end

      assign pix_pad_s[e*PIXEL_SIZE +: PIXEL_SIZE]   = pix_r;
      assign wgt_pad_s[e*WEIGHT_SIZE +: WEIGHT_SIZE] = wgt_r;
    end else begin : g_pad
      assign pix_pad_s[e*PIXEL_SIZE +: PIXEL_SIZE]   = {PIXEL_SIZE{1'b0}};
      assign wgt_pad_s[e*WEIGHT_SIZE +: WEIGHT_SIZE] = {WEIGHT_SIZE{1'b0}};
    end
  end

  // Beat multiplexer: selects the PARALLEL consecutive slots of beat beat_sel_s
  always_comb begin
    beat_pix_s = {PIX_BUS_W{1'b0}};
    beat_wgt_s = {WGT_BUS_W{1'b0}};
    for (int k = 0; k < BEATS; k++) begin
      beat_pix_s = beat_pix_s | ((beat_sel_s == BEAT_W'(k)) ?
                   pix_pad_s[k*PIX_BUS_W +: PIX_BUS_W] : {PIX_BUS_W{1'b0}});
      beat_wgt_s = beat_wgt_s | ((beat_sel_s == BEAT_W'(k)) ?
                   wgt_pad_s[k*WGT_BUS_W +: WGT_BUS_W] : {WGT_BUS_W{1'b0}});
    end
  end

  // Next-state and next-output logic; beat_sel_s names the beat to show next cycle
  always_comb begin
    state_nxt_s     = state_r;
    beat_nxt_s      = beat_r;
    beat_sel_s      = beat_r;
    drain_nxt_s     = drain_r;
    bus_en_s        = 1'b0;
    dp_reset_nxt_s  = 1'b0;
    res_valid_nxt_s = res_valid_r;
    res_value_nxt_s = res_value_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s    = ST_CLEAR;
          dp_reset_nxt_s = 1'b1;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        state_nxt_s = ST_STREAM;
        beat_nxt_s  = {BEAT_W{1'b0}};
        beat_sel_s  = {BEAT_W{1'b0}};
        bus_en_s    = 1'b1;
      end

      ST_STREAM: begin
        if (beat_r == LAST_BEAT) begin
          state_nxt_s = ST_DRAIN;
          drain_nxt_s = {DRAIN_W{1'b0}};
        end else begin
          beat_nxt_s  = beat_r + BEAT_ONE;
          beat_sel_s  = beat_r + BEAT_ONE;
          bus_en_s    = 1'b1;
        end
      end

      ST_DRAIN: begin
        // The engine result is sampled on the last drain edge
        if (drain_r == LAST_DRAIN) begin
          state_nxt_s     = ST_DONE;
          drain_nxt_s     = {DRAIN_W{1'b0}};
          res_valid_nxt_s = 1'b1;
          res_value_nxt_s = dp_value;
        end else begin
          drain_nxt_s     = drain_r + DRAIN_ONE;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_nxt_s     = ST_IDLE;
          beat_nxt_s      = {BEAT_W{1'b0}};
          res_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s     = ST_DONE;
        end
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        beat_nxt_s      = {BEAT_W{1'b0}};
        drain_nxt_s     = {DRAIN_W{1'b0}};
        res_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_r     <= ST_IDLE;
      beat_r      <= {BEAT_W{1'b0}};
      drain_r     <= {DRAIN_W{1'b0}};
      busy_r      <= 1'b0;
      dp_reset_r  <= 1'b0;
      pixels_r    <= {PIX_BUS_W{1'b0}};
      weights_r   <= {WGT_BUS_W{1'b0}};
      res_valid_r <= 1'b0;
      res_value_r <= {VAL_SIZE{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      beat_r      <= beat_nxt_s;
      drain_r     <= drain_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      dp_reset_r  <= dp_reset_nxt_s;
      pixels_r    <= bus_en_s ? beat_pix_s : {PIX_BUS_W{1'b0}};
      weights_r   <= bus_en_s ? beat_wgt_s : {WGT_BUS_W{1'b0}};
      res_valid_r <= res_valid_nxt_s;
      res_value_r <= res_value_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign dp_reset  = dp_reset_r;
  assign Pixels    = pixels_r;
  assign Weights   = weights_r;
  assign res_valid = res_valid_r;
  assign res_value = res_value_r;

endmodule
